// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// One transaction runs at a time: IDLE -> ISSUE -> (CAPTURE) -> ACK.
// All outputs are registered and are set on the edge that enters a state.
module mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r0_req,
  input  logic                  r0_write,
  input  logic [ADDR_WIDTH-1:0] r0_address,
  input  logic [DATA_WIDTH-1:0] r0_data_in,
  output logic                  r0_ack,
  output logic [DATA_WIDTH-1:0] r0_data_out,
  input  logic                  r1_req,
  input  logic                  r1_write,
  input  logic [ADDR_WIDTH-1:0] r1_address,
  input  logic [DATA_WIDTH-1:0] r1_data_in,
  output logic                  r1_ack,
  output logic [DATA_WIDTH-1:0] r1_data_out,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_write_enable,
  output logic                  mem_read_enable,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, ACK} state_t;

  state_t                state_q;
  logic                  last_grant_q;  // port served most recently
  logic                  grant_q;       // port owning the in-flight transaction
  logic                  write_q;

  logic                  grant_d;
  logic                  write_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] data_d;

  // Pick the winner among current requests and mux its request fields.
  always_comb begin
    grant_d = 1'b0;
    if (r0_req && r1_req) grant_d = ~last_grant_q;
    else if (r1_req)      grant_d = 1'b1;
    write_d = grant_d ? r1_write   : r0_write;
    addr_d  = grant_d ? r1_address : r0_address;
    data_d  = grant_d ? r1_data_in : r0_data_in;
  end

  // Transaction FSM with registered strobes, acks, read data and busy.
  // The request fields are captured straight into the memory-side output
  // registers at grant, so later requester changes cannot reach the memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      last_grant_q     <= 1'b1;
      grant_q          <= 1'b0;
      write_q          <= 1'b0;
      r0_ack           <= 1'b0;
      r1_ack           <= 1'b0;
      r0_data_out      <= '0;
      r1_data_out      <= '0;
      mem_address      <= '0;
      mem_write_enable <= 1'b0;
      mem_read_enable  <= 1'b0;
      mem_data_in      <= '0;
      busy             <= 1'b0;
    end else begin
      r0_ack           <= 1'b0;
      r1_ack           <= 1'b0;
      mem_address      <= '0;
      mem_write_enable <= 1'b0;
      mem_read_enable  <= 1'b0;
      mem_data_in      <= '0;
      case (state_q)
        IDLE: begin
          if (r0_req || r1_req) begin
            grant_q     <= grant_d;
            write_q     <= write_d;
            mem_address <= addr_d;
            if (write_d) begin
              mem_write_enable <= 1'b1;
              mem_data_in      <= data_d;
            end else begin
              mem_read_enable  <= 1'b1;
            end
            busy    <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (write_q) begin
            r0_ack  <= ~grant_q;
            r1_ack  <= grant_q;
            state_q <= ACK;
          end else begin
            state_q <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (grant_q) r1_data_out <= mem_data_out;
          else         r0_data_out <= mem_data_out;
          r0_ack  <= ~grant_q;
          r1_ack  <= grant_q;
          state_q <= ACK;
        end
        ACK: begin
          last_grant_q <= grant_q;
          busy         <= 1'b0;
          state_q      <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, word width of the shared data memory.
REQ-002 Parameter ADDR_WIDTH, default 5, address width of the shared data memory.
REQ-003 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1, reset, asynchronous, active-high.
REQ-005 Ports r0_req / r1_req, input, 1, requester 0/1 access request, level, held until ack.
REQ-006 Ports r0_write / r1_write, input, 1, 1 = write, 0 = read.
REQ-007 Ports r0_address / r1_address, input, ADDR_WIDTH, target word address.
REQ-008 Ports r0_data_in / r1_data_in, input, DATA_WIDTH, write data.
REQ-009 Ports r0_ack / r1_ack, output, 1, one-cycle completion pulse.
REQ-010 Ports r0_data_out / r1_data_out, output, DATA_WIDTH, last read data returned to that requester.
REQ-011 Port mem_address, output, ADDR_WIDTH, address to Memory.
REQ-012 Ports mem_write_enable / mem_read_enable, output, 1, Memory strobes.
REQ-013 Port mem_data_in, output, DATA_WIDTH, write data to Memory.
REQ-014 Port mem_data_out, input, DATA_WIDTH, Memory read data, valid the cycle after mem_read_enable is high.
REQ-015 Port busy, output, 1, high whenever state is not IDLE.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, CAPTURE, ACK.
REQ-017 IDLE: no req -> stay; any req -> grant, latch winner's write/address/data_in, go ISSUE.
REQ-018 Arbitration: single requester wins; both requesting -> the one not granted last (round-robin via last_grant register).
REQ-019 ISSUE (exactly one cycle): drive latched address; write -> mem_write_enable=1, mem_data_in=latched data, next ACK; read -> mem_read_enable=1, next CAPTURE.
REQ-020 CAPTURE: register mem_data_out into the granted port's data_out; next ACK.
REQ-021 ACK: pulse granted port's ack for one cycle; update last_grant; next IDLE.
REQ-022 Latency from req sampled in IDLE at edge N: write ack high in cycle N+2; read ack high in cycle N+3 with data_out already valid.
REQ-023 mem_write_enable and mem_read_enable SHALL never be high together and SHALL be low outside ISSUE.
REQ-024 mem_address/mem_data_in SHALL be 0 outside ISSUE.
REQ-025 Requester inputs changing after grant SHALL NOT affect the in-flight transaction.
REQ-026 req deasserted before ack: transaction still completes and ack still pulses.
REQ-027 req still high in the cycle after ack: treated as a new request, arbitrated normally in IDLE.
REQ-028 rN_data_out SHALL hold its value until the next read by that same port completes; writes and the other port's reads do not change it.
REQ-029 Only the granted port's ack pulses; the other ack stays 0.

Reset
REQ-030 rst high SHALL immediately force: state IDLE, last_grant=1 (r0 wins first tie), all acks 0, both data_out 0, all mem_* outputs 0, busy 0.
REQ-031 rst asserted mid-transaction SHALL abort it with no ack; the pending request is re-arbitrated after rst falls.
REQ-032 The first rising edge after rst deasserts SHALL sample requests normally.

Verification
REQ-033 r0 write addr 1 data 32'h12345678 -> mem_write_enable one cycle with mem_address=1, r0_ack at N+2; then r0 read addr 1 -> r0_data_out=32'h12345678 with r0_ack at N+3.
REQ-034 r0 and r1 request in the same cycle right after reset -> r0 served first, r1 served next; repeat simultaneous requests -> grants alternate r1, r0.
REQ-035 r1 write addr 2 32'hABCDEF01 then r0 read addr 2 -> r0_data_out=32'hABCDEF01, r1_data_out unchanged (0).
REQ-036 r0_address changed 1->3 one cycle after grant -> memory still accessed at address 1.
REQ-037 rst pulsed during CAPTURE of r1 read -> no r1_ack, all outputs 0 within the reset, r1 read completes after rst falls if r1_req still high.
REQ-038 Continuous monitor: read and write strobes never overlap; busy equals (state != IDLE); at most one ack high per cycle.
